// File: rtl/unified_mem_arbiter_pkg.sv
// unified_mem_arbiter_pkg: shared FSM, size-code and owner encodings for the unified memory arbiter
package unified_mem_arbiter_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} state_e;
  typedef enum logic {OWN_IF, OWN_DM} owner_e;
  localparam logic [1:0] SZ_NONE = 2'b00;
  localparam logic [1:0] SZ_WORD = 2'b01;
  localparam logic [1:0] SZ_HALF = 2'b10;
  localparam logic [1:0] SZ_BYTE = 2'b11;
  function automatic logic [1:0] norm_size(input logic [1:0] s);
    return s == SZ_NONE ? SZ_WORD : s;
  endfunction
endpackage

// File: rtl/unified_mem_arbiter_latency_counter.sv
// latency_counter: 4-bit loadable down-counter with zero flag, holds at zero
module latency_counter (
  input  logic       clk,
  input  logic       rst,
  input  logic       load_i,
  input  logic [3:0] load_val_i,
  input  logic       dec_i,
  output logic       zero_o
);
  logic [3:0] cnt_q, cnt_d;
  always_comb cnt_d = load_i ? load_val_i : (dec_i && cnt_q != 4'd0) ? cnt_q - 4'd1 : cnt_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= 4'd0;
    else cnt_q <= cnt_d;
  assign zero_o = cnt_q == 4'd0;
endmodule

// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter: serialises fetch and data-stage accesses onto one fixed-latency memory, DM has priority
module unified_mem_arbiter
  import unified_mem_arbiter_pkg::*;
#(
  parameter int MEM_LATENCY = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        IfReq,
  input  logic [31:0] IfAddr,
  output logic [31:0] IfData,
  output logic        IfDone,
  input  logic        DmReq,
  input  logic        DmWrite,
  input  logic [1:0]  DmSize,
  input  logic [31:0] DmAddr,
  input  logic [31:0] DmWData,
  output logic [31:0] DmRData,
  output logic        DmDone,
  output logic        IfStall,
  output logic        DmStall,
  output logic [31:0] MemAddr,
  output logic [31:0] MemWData,
  output logic [1:0]  MemWrite,
  output logic [1:0]  MemRead,
  input  logic [31:0] MemRData
);
  localparam logic [3:0] LAT_M1 = 4'(MEM_LATENCY - 1);
  state_e      state_q;
  owner_e      owner_q;
  logic [31:0] mem_addr_q, mem_wdata_q, if_data_q, dm_rdata_q;
  logic [1:0]  mem_write_q, mem_read_q;
  logic        if_done_q, dm_done_q, cnt_zero, grant;
  assign grant = state_q == ST_IDLE && (DmReq || IfReq);
  latency_counter u_cnt (
    .clk       (Clk),
    .rst       (Reset),
    .load_i    (grant),
    .load_val_i(LAT_M1),
    .dec_i     (state_q == ST_BUSY),
    .zero_o    (cnt_zero)
  );
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) begin
      state_q     <= ST_IDLE;
      owner_q     <= OWN_IF;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_write_q <= SZ_NONE;
      mem_read_q  <= SZ_NONE;
      if_data_q   <= '0;
      dm_rdata_q  <= '0;
      if_done_q   <= 1'b0;
      dm_done_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE:
          if (DmReq) begin
            state_q     <= ST_BUSY;
            owner_q     <= OWN_DM;
            mem_addr_q  <= DmAddr;
            mem_wdata_q <= DmWrite ? DmWData : '0;
            mem_write_q <= DmWrite ? norm_size(DmSize) : SZ_NONE;
            mem_read_q  <= DmWrite ? SZ_NONE : norm_size(DmSize);
          end else if (IfReq) begin
            state_q     <= ST_BUSY;
            owner_q     <= OWN_IF;
            mem_addr_q  <= IfAddr;
            mem_wdata_q <= '0;
            mem_write_q <= SZ_NONE;
            mem_read_q  <= SZ_WORD;
          end
        ST_BUSY:
          if (cnt_zero) begin
            state_q     <= ST_DONE;
            if_done_q   <= owner_q == OWN_IF;
            dm_done_q   <= owner_q == OWN_DM;
            if (owner_q == OWN_IF) if_data_q <= MemRData;
            if (owner_q == OWN_DM && mem_read_q != SZ_NONE) dm_rdata_q <= MemRData;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_write_q <= SZ_NONE;
            mem_read_q  <= SZ_NONE;
          end
        default: begin
          state_q   <= ST_IDLE;
          if_done_q <= 1'b0;
          dm_done_q <= 1'b0;
        end
      endcase
    end
  assign IfData   = if_data_q;
  assign IfDone   = if_done_q;
  assign DmRData  = dm_rdata_q;
  assign DmDone   = dm_done_q;
  assign MemAddr  = mem_addr_q;
  assign MemWData = mem_wdata_q;
  assign MemWrite = mem_write_q;
  assign MemRead  = mem_read_q;
  assign IfStall  = IfReq & ~if_done_q;
  assign DmStall  = DmReq & ~dm_done_q;
endmodule

// File: tb/tb_unified_mem_arbiter.sv
// tb_unified_mem_arbiter: directed checks of arbitration, timing, reset, and latency 1/15 streaming fetch
module tb_unified_mem_arbiter;
  logic        Clk = 1'b0, Reset = 1'b1;
  logic        IfReq = 1'b0, DmReq = 1'b0, DmWrite = 1'b0;
  logic [1:0]  DmSize = 2'b01;
  logic [31:0] IfAddr = '0, DmAddr = '0, DmWData = '0, MemRData = '0;
  logic [31:0] IfData, DmRData, MemAddr, MemWData;
  logic        IfDone, DmDone, IfStall, DmStall;
  logic [1:0]  MemWrite, MemRead;
  int checks = 0, failures = 0;
  always #5 Clk = ~Clk;

  unified_mem_arbiter #(.MEM_LATENCY(2)) u_dut (
    .Clk(Clk), .Reset(Reset), .IfReq(IfReq), .IfAddr(IfAddr), .IfData(IfData), .IfDone(IfDone),
    .DmReq(DmReq), .DmWrite(DmWrite), .DmSize(DmSize), .DmAddr(DmAddr), .DmWData(DmWData),
    .DmRData(DmRData), .DmDone(DmDone), .IfStall(IfStall), .DmStall(DmStall), .MemAddr(MemAddr),
    .MemWData(MemWData), .MemWrite(MemWrite), .MemRead(MemRead), .MemRData(MemRData)
  );

  function automatic logic [31:0] pat(input logic [31:0] a);
    return {~a[15:0], a[15:0]};
  endfunction

  logic        req_s = 1'b0;
  logic [31:0] a1 = 32'h1000, a15 = 32'h2000;
  logic [31:0] d1, d15, ma1, ma15, wd1, wd15, rd1, rd15;
  logic        dn1, dn15, dd1, dd15, is1, is15, ds1, ds15;
  logic [1:0]  mw1, mw15, mr1, mr15;
  unified_mem_arbiter #(.MEM_LATENCY(1)) u_l1 (
    .Clk(Clk), .Reset(Reset), .IfReq(req_s), .IfAddr(a1), .IfData(d1), .IfDone(dn1),
    .DmReq(1'b0), .DmWrite(1'b0), .DmSize(2'b01), .DmAddr(32'h0), .DmWData(32'h0),
    .DmRData(rd1), .DmDone(dd1), .IfStall(is1), .DmStall(ds1), .MemAddr(ma1),
    .MemWData(wd1), .MemWrite(mw1), .MemRead(mr1), .MemRData(pat(ma1))
  );
  unified_mem_arbiter #(.MEM_LATENCY(15)) u_l15 (
    .Clk(Clk), .Reset(Reset), .IfReq(req_s), .IfAddr(a15), .IfData(d15), .IfDone(dn15),
    .DmReq(1'b0), .DmWrite(1'b0), .DmSize(2'b01), .DmAddr(32'h0), .DmWData(32'h0),
    .DmRData(rd15), .DmDone(dd15), .IfStall(is15), .DmStall(ds15), .MemAddr(ma15),
    .MemWData(wd15), .MemWrite(mw15), .MemRead(mr15), .MemRData(pat(ma15))
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge Clk);
  endtask

  initial begin
    int n1, n15, nx1, nx15;
    cyc(); cyc();
    chk("rst_memread", 32'(MemRead), 0);
    chk("rst_memaddr", MemAddr, 0);
    chk("rst_ifdata", IfData, 0);
    chk("rst_done", {30'd0, IfDone, DmDone}, 0);
    Reset = 1'b0;
    cyc();
    // fetch alone, latency 2
    IfReq = 1'b1; IfAddr = 32'h10; MemRData = 32'h2008_0005;
    #1 chk("t1_stall_c0", 32'(IfStall), 1);
    cyc();
    chk("t1_rd_c1", 32'(MemRead), 32'h1);
    chk("t1_addr_c1", MemAddr, 32'h10);
    cyc();
    chk("t1_rd_c2", 32'(MemRead), 32'h1);
    chk("t1_stall_c2", 32'(IfStall), 1);
    cyc();
    chk("t1_done_c3", 32'(IfDone), 1);
    chk("t1_data_c3", IfData, 32'h2008_0005);
    chk("t1_stall_c3", 32'(IfStall), 0);
    chk("t1_rd_c3", 32'(MemRead), 0);
    IfReq = 1'b0;
    cyc();
    chk("t1_done_c4", 32'(IfDone), 0);
    chk("t1_hold_c4", IfData, 32'h2008_0005);
    // simultaneous requests: DM first
    IfReq = 1'b1; IfAddr = 32'h100; DmReq = 1'b1; DmWrite = 1'b0; DmSize = 2'b01; DmAddr = 32'h40;
    MemRData = 32'h1111_2222;
    cyc();
    chk("t2_addr_c1", MemAddr, 32'h40);
    chk("t2_rd_c1", 32'(MemRead), 32'h1);
    chk("t2_stall_c1", {30'd0, IfStall, DmStall}, 32'h3);
    cyc();
    cyc();
    chk("t2_dmdone_c3", {30'd0, IfDone, DmDone}, 32'h1);
    chk("t2_dmdata_c3", DmRData, 32'h1111_2222);
    chk("t2_dmstall_c3", 32'(DmStall), 0);
    DmReq = 1'b0; MemRData = 32'h3333_4444;
    cyc();
    chk("t2_idle_c4", 32'(MemRead), 0);
    chk("t2_ifstall_c4", 32'(IfStall), 1);
    cyc();
    chk("t2_ifaddr_c5", MemAddr, 32'h100);
    chk("t2_ifrd_c5", 32'(MemRead), 32'h1);
    cyc();
    chk("t2_ifdone_c6", 32'(IfDone), 0);
    cyc();
    chk("t2_ifdone_c7", 32'(IfDone), 1);
    chk("t2_ifdata_c7", IfData, 32'h3333_4444);
    chk("t2_dmhold_c7", DmRData, 32'h1111_2222);
    IfReq = 1'b0;
    cyc();
    // byte store
    DmReq = 1'b1; DmWrite = 1'b1; DmSize = 2'b11; DmAddr = 32'h13; DmWData = 32'hAB; MemRData = 32'hDEAD_BEEF;
    cyc();
    chk("t3_wr_c1", {28'd0, MemWrite, MemRead}, 32'hC);
    chk("t3_wd_c1", MemWData, 32'hAB);
    chk("t3_addr_c1", MemAddr, 32'h13);
    cyc();
    chk("t3_wr_c2", {28'd0, MemWrite, MemRead}, 32'hC);
    cyc();
    chk("t3_done_c3", 32'(DmDone), 1);
    chk("t3_rdata_c3", DmRData, 32'h1111_2222);
    chk("t3_wr_c3", 32'(MemWrite), 0);
    DmReq = 1'b0;
    cyc();
    // size 00 behaves as word; reset mid-BUSY
    DmReq = 1'b1; DmWrite = 1'b0; DmSize = 2'b00; DmAddr = 32'h20; MemRData = 32'h7777_7777;
    cyc();
    chk("t4_rd_sz0", 32'(MemRead), 32'h1);
    Reset = 1'b1;
    #1 chk("t4_rst_rd", 32'(MemRead), 0);
    chk("t4_rst_addr", MemAddr, 0);
    chk("t4_rst_data", DmRData | IfData, 0);
    cyc();
    DmReq = 1'b0; Reset = 1'b0;
    cyc();
    chk("t4_nodone_a", {30'd0, IfDone, DmDone}, 0);
    cyc();
    chk("t4_nodone_b", {30'd0, IfDone, DmDone}, 0);
    IfReq = 1'b1; IfAddr = 32'h200; MemRData = 32'h5555_AAAA;
    cyc(); cyc(); cyc();
    chk("t4_done", 32'(IfDone), 1);
    chk("t4_data", IfData, 32'h5555_AAAA);
    IfReq = 1'b0;
    cyc();
    // streaming fetch on latency 1 and 15 builds
    req_s = 1'b1;
    n1 = 0; n15 = 0; nx1 = 2; nx15 = 16;
    for (int c = 1; c <= 120; c++) begin
      cyc();
      chk("s1_done", 32'(dn1), 32'(c == nx1));
      chk("s15_done", 32'(dn15), 32'(c == nx15));
      if (c == nx1) begin
        chk("s1_data", d1, pat(a1));
        a1 = a1 + 32'd4; nx1 += 3; n1++;
      end
      if (c == nx15) begin
        chk("s15_data", d15, pat(a15));
        a15 = a15 + 32'd4; nx15 += 17; n15++;
      end
    end
    chk("s1_count", n1, 40);
    chk("s15_count", n15, 7);
    req_s = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/unified_mem_arbiter.md
# unified_mem_arbiter

Arbiter and sequencer that shares one single-ported, fixed-latency unified memory between the instruction-fetch stage and the data-memory stage of the 5-stage MIPS pipeline. It serialises the two requesters, drives the memory command bus, returns read data with a one-cycle done pulse, and produces per-stage stall signals that freeze the pipeline registers while an access is outstanding.

## Interface
Parameters:
- MEM_LATENCY, 2: cycles the memory command must be held before read data is valid; legal range 1..15.

Ports:
- Clk  in  1  single clock; all state updates on rising edge.
- Reset  in  1  asynchronous, active-high.
- IfReq  in  1  fetch requests an instruction read at IfAddr.
- IfAddr  in  32  fetch byte address.
- IfData  out  32  instruction; valid while IfDone=1, held afterwards.
- IfDone  out  1  one-cycle pulse, fetch access complete.
- DmReq  in  1  data-stage access request.
- DmWrite  in  1  1 = store, 0 = load.
- DmSize  in  2  01 word, 10 half, 11 byte; 00 is treated as 01.
- DmAddr  in  32  data byte address.
- DmWData  in  32  store data.
- DmRData  out  32  load data; valid while DmDone=1, held afterwards.
- DmDone  out  1  one-cycle pulse, data access complete (loads and stores).
- IfStall  out  1  IfReq & ~IfDone (combinational).
- DmStall  out  1  DmReq & ~DmDone (combinational).
- MemAddr  out  32  memory address.
- MemWData  out  32  memory write data.
- MemWrite  out  2  size code for write, 00 = no write.
- MemRead  out  2  size code for read, 00 = no read.
- MemRData  in  32  memory read data, valid on last command cycle.

## Operation
- FSM states: IDLE, BUSY, DONE.
- IDLE: if DmReq, grant DM; else if IfReq, grant IF; else stay. Fixed priority DM > IF (DM belongs to the older instruction; no starvation since the pipeline advances once DM completes).
- Grant: register owner, load command registers (MemAddr, MemWData, MemWrite/MemRead), counter = MEM_LATENCY-1, go BUSY.
- IF grant: MemRead=01, MemWrite=00, MemAddr=IfAddr.
- DM load: MemRead=DmSize, MemWrite=00. DM store: MemWrite=DmSize, MemRead=00, MemWData=DmWData.
- BUSY: command registers held stable; counter decrements each cycle. When counter=0: capture MemRData into IfData or DmRData (loads/fetches only; stores leave DmRData unchanged), clear command registers to zero, assert owner's Done, go DONE.
- DONE: Done high for exactly this cycle; requests ignored (pipeline advances at this edge, request inputs still carry old values); go IDLE.
- Request inputs are sampled only in IDLE; changes during BUSY/DONE have no effect on the active access.
- Both requests simultaneous: DM served first, IF served starting in the following IDLE cycle.

## Timing
- Request high in cycle 0 (state IDLE) -> command on bus cycles 1..MEM_LATENCY -> Done and data valid cycle MEM_LATENCY+1 (DONE) -> IDLE cycle MEM_LATENCY+2.
- Back-to-back throughput: one access per MEM_LATENCY+2 cycles.
- Stall high from cycle 0 through cycle MEM_LATENCY, low in the Done cycle.
- Reset (any time, including mid-BUSY): state IDLE, counter 0, MemAddr/MemWData 0, MemWrite/MemRead 00, IfData/DmRData 0, IfDone/DmDone 0; in-flight access abandoned, no Done issued.

## Structure
- Shared package: FSM state encoding (IDLE/BUSY/DONE), size codes (SZ_NONE=00, SZ_WORD=01, SZ_HALF=10, SZ_BYTE=11), owner encoding (OWN_IF, OWN_DM).
- One natural sub-module: latency_counter (4-bit load/decrement with zero flag).

## Test plan
- Reset, IfReq=1, IfAddr=0x0000_0010, MEM_LATENCY=2, MemRData=0x2008_0005 -> MemRead=01 cycles 1–2, IfDone and IfData=0x2008_0005 in cycle 3, IfStall low in cycle 3.
- IfReq and DmReq (load, DmSize=01, DmAddr=0x40) both high in cycle 0 -> DM served cycles 1–2, DmDone cycle 3, IF command starts cycle 5, IfDone cycle 7.
- Store DmSize=11, DmAddr=0x13, DmWData=0xAB -> MemWrite=11, MemRead=00 for MEM_LATENCY cycles, DmDone pulses, DmRData unchanged.
- Reset asserted in middle of BUSY -> all outputs zero immediately, no Done pulse; after release, a fresh IfReq completes normally.
- MEM_LATENCY=1 and =15 builds, continuous IfReq with incrementing addresses -> one IfDone every 3 and 17 cycles respectively, data matches address-derived pattern.
